// File: rtl/fir_seq_mac.sv
// Runtime-configurable FIR: AXI-Lite config/status, AXI-Stream in/out, one shared MAC stepping one tap per cycle.
// Latency: input handshake at cycle t -> sm_tvalid at t+NTAP+1; one sample per NTAP+2 cycles.
// Backpressure: ss_tready only in IN; a result is held in OUT until sm_tready; AXI-Lite read data held until rready.
module fir_seq_mac #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTAP_MAX    = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awready,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready
);
    localparam int TW = $clog2(pTAP_MAX);
    localparam int W  = pDATA_WIDTH;
    localparam int AW = 2*W + TW;
    localparam logic [pADDR_WIDTH-1:0] A_CTRL = 'h00;
    localparam logic [pADDR_WIDTH-1:0] A_MODE = 'h04;
    localparam logic [pADDR_WIDTH-1:0] A_LEN  = 'h10;
    localparam logic [pADDR_WIDTH-1:0] A_NTAP = 'h14;
    localparam logic [pADDR_WIDTH-1:0] A_COEF = 'h80;
    localparam logic [pADDR_WIDTH-1:0] A_CEND = A_COEF + pADDR_WIDTH'(4*pTAP_MAX);
    localparam logic [TW:0]  NT_MAX = (TW+1)'(pTAP_MAX);
    localparam logic [W-1:0] SMAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_IN, S_MAC, S_OUT, S_DONE} state_t;
    state_t state_q, state_d;

    logic [W-1:0]    coef_q [pTAP_MAX];
    logic [W-1:0]    hist_q [pTAP_MAX];
    logic [TW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TW:0]     k_q, k_d, ntap_q, ntap_w;
    logic [AW-1:0]   acc_q, acc_d;
    logic [W-1:0]    count_q, count_d, len_q, rdata_q, rd_mux;
    logic            sat_en_q, ap_done_q, ap_idle_q, start_q, rvalid_q, live_q;
    logic            wr_en, start_wr, launch, cfg_wr, ss_hs, rd_hs, wr_coef, rd_coef, fits;
    logic [TW-1:0]   wr_idx, rd_idx;
    logic signed [2*W-1:0] prod;
    logic [W+TW:0]   acc_hi;
    logic            unused_tlast;

    assign unused_tlast = ss_tlast;
    assign wr_en    = awvalid & wvalid;
    assign awready  = wr_en;
    assign wready   = wr_en;
    assign start_wr = wr_en && (awaddr == A_CTRL) && wdata[0];
    assign launch   = start_wr && (state_q == S_IDLE);
    assign cfg_wr   = wr_en && ap_idle_q;
    assign ss_tready = (state_q == S_IN);
    assign ss_hs    = ss_tvalid && ss_tready;
    assign arready  = live_q && !rvalid_q;
    assign rd_hs    = arvalid && arready;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;

    assign wr_coef = (awaddr >= A_COEF) && (awaddr < A_CEND) && (awaddr[1:0] == 2'b00);
    assign rd_coef = (araddr >= A_COEF) && (araddr < A_CEND) && (araddr[1:0] == 2'b00);
    assign wr_idx  = TW'((awaddr - A_COEF) >> 2);
    assign rd_idx  = TW'((araddr - A_COEF) >> 2);

    // rptr walks backwards from the newest sample, so x[n-k] lines up with h[k]
    assign prod   = $signed(hist_q[rptr_q]) * $signed(coef_q[k_q[TW-1:0]]);
    assign acc_hi = acc_q[AW-1:W-1];
    assign fits   = (&acc_hi) | ~(|acc_hi);

    assign sm_tvalid = (state_q == S_OUT);
    assign sm_tlast  = sm_tvalid && ((count_q + W'(1)) == len_q);
    assign sm_tdata  = !sm_tvalid ? '0 :
                       (!sat_en_q || fits) ? acc_q[W-1:0] :
                       (acc_q[AW-1] ? SMIN : SMAX);

    always_comb begin
        ntap_w = wdata[TW:0];
        if (wdata == '0)
            ntap_w = (TW+1)'(1);
        else if (wdata > W'(pTAP_MAX))
            ntap_w = NT_MAX;
    end

    always_comb begin
        rd_mux = '0;
        if (araddr == A_CTRL)      rd_mux = W'({ap_idle_q, ap_done_q, start_q});
        else if (araddr == A_MODE) rd_mux = W'(sat_en_q);
        else if (araddr == A_LEN)  rd_mux = len_q;
        else if (araddr == A_NTAP) rd_mux = W'(ntap_q);
        else if (rd_coef)          rd_mux = coef_q[rd_idx];
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        k_d     = k_q;
        acc_d   = acc_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: if (start_wr) begin
                count_d = '0;
                wptr_d  = '0;
                state_d = (len_q == '0) ? S_DONE : S_IN;
            end
            S_IN: if (ss_tvalid) begin
                rptr_d  = wptr_q;
                wptr_d  = wptr_q + TW'(1);
                k_d     = '0;
                acc_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d  = acc_q + {{TW{prod[2*W-1]}}, prod};
                rptr_d = rptr_q - TW'(1);
                k_d    = k_q + (TW+1)'(1);
                // a zero NTAP (reset value) still runs one tap
                if ((k_q + (TW+1)'(1)) >= ntap_q)
                    state_d = S_OUT;
            end
            S_OUT: if (sm_tready) begin
                count_d = count_q + W'(1);
                state_d = (count_d == len_q) ? S_DONE : S_IN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < pTAP_MAX; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
            len_q     <= '0;
            ntap_q    <= '0;
            sat_en_q  <= 1'b0;
            ap_done_q <= 1'b0;
            ap_idle_q <= 1'b1;
            start_q   <= 1'b0;
            live_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            live_q  <= 1'b1;
            start_q <= launch;
            if (launch) begin
                for (int i = 0; i < pTAP_MAX; i++)
                    hist_q[i] <= '0;
            end else if (ss_hs) begin
                hist_q[wptr_q] <= ss_tdata;
            end
            if (cfg_wr) begin
                if (awaddr == A_MODE) sat_en_q <= wdata[0];
                if (awaddr == A_LEN)  len_q    <= wdata;
                if (awaddr == A_NTAP) ntap_q   <= ntap_w;
                if (wr_coef)          coef_q[wr_idx] <= wdata;
            end
            if (launch) begin
                ap_done_q <= 1'b0;
                ap_idle_q <= 1'b0;
            end else if (state_q == S_DONE) begin
                ap_done_q <= 1'b1;
                ap_idle_q <= 1'b1;
            end else if (rd_hs && (araddr == A_CTRL)) begin
                ap_done_q <= 1'b0;
            end
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench for fir_seq_mac: expected results are hand-computed constants.
module tb_fir_seq_mac;
    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic        awready, wready, arready, rvalid;
    logic        ss_tvalid = 0, ss_tlast = 0, ss_tready;
    logic [31:0] ss_tdata = '0, sm_tdata;
    logic        sm_tvalid, sm_tlast, sm_tready = 1'b1;

    int n_chk = 0;
    int n_pass = 0;

    always #5 axis_clk = ~axis_clk;

    fir_seq_mac dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic axil_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge axis_clk);
        awvalid = 1; wvalid = 1; awaddr = a; wdata = d;
        @(negedge axis_clk);
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axil_rd(input logic [11:0] a, output logic [31:0] d);
        int t;
        @(negedge axis_clk);
        arvalid = 1; araddr = a;
        t = 0;
        while (!arready && t < 20) begin @(negedge axis_clk); t++; end
        @(negedge axis_clk);
        arvalid = 0;
        t = 0;
        while (!rvalid && t < 20) begin @(negedge axis_clk); t++; end
        chk("rvalid", rvalid, 1);
        d = rdata;
        rready = 1;
        @(negedge axis_clk);
        rready = 0;
    endtask

    task automatic send(input logic [31:0] x);
        int t;
        @(negedge axis_clk);
        ss_tvalid = 1; ss_tdata = x;
        t = 0;
        while (!ss_tready && t < 300) begin @(negedge axis_clk); t++; end
        chk("ss_tready", ss_tready, 1);
        @(negedge axis_clk);
        ss_tvalid = 0;
    endtask

    task automatic get_out(output logic [31:0] d, output logic l, output int lat);
        lat = 0;
        while (!sm_tvalid && lat < 300) begin @(negedge axis_clk); lat++; end
        chk("sm_tvalid", sm_tvalid, 1);
        d = sm_tdata; l = sm_tlast;
        @(negedge axis_clk);
    endtask

    initial begin
        logic [31:0] rd, y, d0;
        logic        l, ok;
        int          lat;
        logic [31:0] exp_y [4];
        exp_y[0] = 1; exp_y[1] = 4; exp_y[2] = 10; exp_y[3] = 16;

        repeat (3) @(negedge axis_clk);
        chk("rst_ctl", {arready, awready, wready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 0);
        chk("rst_dat", {rdata, sm_tdata}, 0);
        axis_rst_n = 1;
        axil_rd(12'h000, rd); chk("ctrl_after_rst", rd, 32'h4);

        // basic 3-tap frame, with an ignored restart and a discarded coefficient write mid-frame
        axil_wr(12'h014, 3);
        axil_wr(12'h080, 1); axil_wr(12'h084, 2); axil_wr(12'h088, 3);
        axil_wr(12'h010, 4); axil_wr(12'h004, 0);
        axil_rd(12'h014, rd); chk("ntap_rd", rd, 3);
        axil_wr(12'h000, 1);
        send(1); get_out(y, l, lat);
        chk("y0", y, 1); chk("last0", l, 0); chk("latency", lat, 3);
        axil_wr(12'h000, 1);
        axil_wr(12'h080, 99);
        axil_rd(12'h080, rd); chk("coef_busy", rd, 1);
        axil_rd(12'h000, rd); chk("ctrl_busy", rd, 0);
        for (int i = 1; i < 4; i++) begin
            send(32'(i + 1)); get_out(y, l, lat);
            chk("y", y, exp_y[i]); chk("last", l, (i == 3) ? 1 : 0);
        end
        chk("no_extra_out", sm_tvalid, 0);
        axil_rd(12'h000, rd); chk("done_rd1", rd, 32'h6);
        axil_rd(12'h000, rd); chk("done_rd2", rd, 32'h4);

        // output backpressure on the second result
        axil_wr(12'h000, 1);
        send(1); get_out(y, l, lat); chk("bp_y0", y, 1);
        sm_tready = 0;
        send(2);
        lat = 0;
        while (!sm_tvalid && lat < 300) begin @(negedge axis_clk); lat++; end
        d0 = sm_tdata; ok = 1;
        repeat (5) begin
            @(negedge axis_clk);
            if (sm_tvalid !== 1'b1 || sm_tdata !== d0 || ss_tready !== 1'b0) ok = 0;
        end
        chk("bp_y1", d0, 4); chk("bp_stable", ok, 1);
        sm_tready = 1;
        @(negedge axis_clk);
        for (int i = 2; i < 4; i++) begin
            send(32'(i + 1)); get_out(y, l, lat);
            chk("bp_y", y, exp_y[i]);
        end

        // wrap vs saturation, single tap; NTAP=0 clamps to 1
        axil_wr(12'h014, 0);
        axil_rd(12'h014, rd); chk("ntap_min", rd, 1);
        axil_wr(12'h080, 32'h7FFF_FFFF); axil_wr(12'h010, 1);
        axil_wr(12'h000, 1); send(2); get_out(y, l, lat);
        chk("wrap_pos", y, 32'hFFFF_FFFE); chk("wrap_last", l, 1);
        axil_wr(12'h004, 1);
        axil_wr(12'h000, 1); send(2); get_out(y, l, lat);
        chk("sat_pos", y, 32'h7FFF_FFFF);
        axil_wr(12'h080, 32'h8000_0000);
        axil_wr(12'h000, 1); send(2); get_out(y, l, lat);
        chk("sat_neg", y, 32'h8000_0000);

        // full-depth impulse response over two history wraps; NTAP above max clamps
        axil_wr(12'h014, 100);
        axil_rd(12'h014, rd); chk("ntap_max", rd, 32);
        for (int i = 0; i < 32; i++) axil_wr(12'(12'h080 + 4*i), 32'(i + 1));
        axil_wr(12'h010, 64);
        axil_wr(12'h000, 1);
        for (int n = 0; n < 64; n++) begin
            send((n == 0) ? 32'd1 : 32'd0); get_out(y, l, lat);
            chk("imp_y", y, (n < 32) ? 32'(n + 1) : 32'd0);
            if (n == 63) chk("imp_last", l, 1);
        end

        // LEN=0 finishes without accepting input
        axil_wr(12'h010, 0);
        axil_wr(12'h000, 1);
        chk("len0_no_tready", ss_tready, 0);
        axil_rd(12'h000, rd); chk("len0_done", rd, 32'h6);

        // reset in the middle of a MAC sweep
        axil_wr(12'h010, 4);
        axil_wr(12'h000, 1);
        send(5);
        @(negedge axis_clk);
        axis_rst_n = 0;
        #1;
        chk("mid_rst_ctl", {arready, awready, wready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 0);
        chk("mid_rst_dat", sm_tdata, 0);
        @(negedge axis_clk);
        axis_rst_n = 1;
        ok = 1;
        repeat (40) begin
            @(negedge axis_clk);
            if (sm_tvalid !== 1'b0 || ss_tready !== 1'b0) ok = 0;
        end
        chk("post_rst_quiet", ok, 1);
        axil_rd(12'h000, rd); chk("post_rst_ctrl", rd, 32'h4);
        axil_rd(12'h080, rd); chk("post_rst_coef", rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
